// File: rtl/oam_sprite_evaluator_pkg.sv
// Shared types and constants for the sprite OAM evaluator, the OAM storage
// and the line-buffer interface.
package madnes_oam_pkg;

  localparam int OAM_ENTRIES = 64;
  localparam int OAM_ADDR_W  = 6;
  localparam int ATTR_VFLIP  = 7;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] attr;
    logic [7:0] tile;
    logic [7:0] y;
  } oam_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } eval_state_t;

endpackage

// File: rtl/oam_sprite_evaluator_if.sv
// OAM read port plus line sprite buffer write port between the evaluator
// (master) and the memories it talks to (slave).
interface oam_sprite_evaluator_if;
  import madnes_oam_pkg::*;

  // oam_read_data answers oam_read_addr in the same cycle. sprite_we is a
  // one-cycle write strobe qualifying slot/entry/row; there is no back-pressure.
  logic [OAM_ADDR_W-1:0] oam_read_addr;
  logic [31:0]           oam_read_data;
  logic                  sprite_we;
  logic [2:0]            sprite_slot;
  logic [31:0]           sprite_entry;
  logic [3:0]            sprite_row;

  modport master (
    output oam_read_addr,
    input  oam_read_data,
    output sprite_we,
    output sprite_slot,
    output sprite_entry,
    output sprite_row
  );

  modport slave (
    input  oam_read_addr,
    output oam_read_data,
    input  sprite_we,
    input  sprite_slot,
    input  sprite_entry,
    input  sprite_row
  );

endinterface

// File: rtl/oam_sprite_evaluator_mem.sv
// 64-entry sprite OAM: CPU writes 16-bit halves, the evaluator reads whole
// 32-bit entries combinationally.
module oam_memory
  import madnes_oam_pkg::*;
(
  input  logic                  clk,
  input  logic                  cpu_we,
  input  logic [OAM_ADDR_W:0]   cpu_addr,
  input  logic [15:0]           cpu_wdata,
  oam_sprite_evaluator_if.slave rd
);

  logic [15:0] mem_lo_q [OAM_ENTRIES];
  logic [15:0] mem_hi_q [OAM_ENTRIES];

  // cpu_addr[0] selects the half: 0 = y/tile, 1 = attr/x.
  always_ff @(posedge clk) begin
    if (cpu_we) begin
      if (cpu_addr[0]) begin
        mem_hi_q[cpu_addr[OAM_ADDR_W:1]] <= cpu_wdata;
      end else begin
        mem_lo_q[cpu_addr[OAM_ADDR_W:1]] <= cpu_wdata;
      end
    end
  end

  assign rd.oam_read_data = {mem_hi_q[rd.oam_read_addr], mem_lo_q[rd.oam_read_addr]};

endmodule

// File: rtl/oam_sprite_evaluator_range_check.sv
// Combinational vertical hit test of one OAM entry against a scanline,
// producing the row inside the sprite after optional vertical flip.
module sprite_range_check #(
  parameter int SPRITE_HEIGHT = 8
) (
  input  logic [7:0] scanline,
  input  logic [7:0] y,
  input  logic       vflip,
  output logic       hit,
  output logic [3:0] row
);

  logic [8:0] diff;
  logic [3:0] row_raw;

  // The 9th bit catches y above the scanline, so sprites never wrap past 255.
  always_comb begin
    diff    = {1'b0, scanline} - {1'b0, y};
    hit     = (diff[8] == 1'b0) && (diff < 9'(SPRITE_HEIGHT));
    row_raw = diff[3:0];
    row     = vflip ? (4'(SPRITE_HEIGHT - 1) - row_raw) : row_raw;
  end

endmodule

// File: rtl/oam_sprite_evaluator.sv
// Per-scanline sprite evaluator: scans all OAM entries in fixed 64 cycles and
// writes up to MAX_SPRITES hits into the line sprite buffer.
module oam_sprite_evaluator
  import madnes_oam_pkg::*;
#(
  parameter int NUM_ENTRIES   = 64,
  parameter int MAX_SPRITES   = 8,
  parameter int SPRITE_HEIGHT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             scanline,
  oam_sprite_evaluator_if.master oam_bus,
  output logic [3:0]             sprite_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done,
  output eval_state_t            dbg_state
);

  localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [3:0]            MAX_CNT   = 4'(MAX_SPRITES);

  eval_state_t           state_q, state_d;
  logic [7:0]            scanline_q, scanline_d;
  logic [OAM_ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]            count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  we_q, we_d;
  logic [2:0]            slot_q, slot_d;
  logic [31:0]           entry_q, entry_d;
  logic [3:0]            row_q, row_d;
  logic                  done_q, done_d;

  oam_entry_t ent;
  logic       hit;
  logic [3:0] hit_row;

  assign ent = oam_entry_t'(oam_bus.oam_read_data);

  sprite_range_check #(
    .SPRITE_HEIGHT(SPRITE_HEIGHT)
  ) u_range_check (
    .scanline (scanline_q),
    .y        (ent.y),
    .vflip    (ent.attr[ATTR_VFLIP]),
    .hit      (hit),
    .row      (hit_row)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      scanline_q <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      we_q       <= 1'b0;
      slot_q     <= '0;
      entry_q    <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scanline_q <= scanline_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      we_q       <= we_d;
      slot_q     <= slot_d;
      entry_q    <= entry_d;
      row_q      <= row_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scanline_d = scanline_q;
    addr_d     = addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we_d       = 1'b0;
    slot_d     = slot_q;
    entry_d    = entry_q;
    row_d      = row_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SCAN;
          scanline_d = scanline;
          addr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          if (count_q < MAX_CNT) begin
            we_d    = 1'b1;
            slot_d  = count_q[2:0];
            entry_d = ent;
            row_d   = hit_row;
            count_d = count_q + 4'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // No early exit: every line costs exactly NUM_ENTRIES cycles.
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oam_bus.oam_read_addr = addr_q;
  assign oam_bus.sprite_we     = we_q;
  assign oam_bus.sprite_slot   = slot_q;
  assign oam_bus.sprite_entry  = entry_q;
  assign oam_bus.sprite_row    = row_q;
  assign sprite_count          = count_q;
  assign overflow              = overflow_q;
  assign busy                  = (state_q == ST_SCAN);
  assign done                  = done_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// Bench for oam_sprite_evaluator: an 8-line and a 16-line instance share one
// OAM image and start/scanline stimulus; buffer writes are scoreboarded.
module tb_oam_sprite_evaluator;
  import madnes_oam_pkg::*;

  localparam int W = 39;  // {slot[2:0], entry[31:0], row[3:0]}

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  scanline = 8'd0;
  logic        cpu_we = 1'b0;
  logic [6:0]  cpu_addr = 7'd0;
  logic [15:0] cpu_wdata = 16'd0;

  logic [3:0]  count8, count16;
  logic        ov8, ov16, busy8, busy16, done8, done16;
  eval_state_t st8, st16;

  int checks = 0;
  int errors = 0;
  logic [31:0]  shadow [64];
  logic [W-1:0] exp8_q[$];
  logic [W-1:0] exp16_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  oam_sprite_evaluator_if bus8();
  oam_sprite_evaluator_if bus16();

  oam_memory u_mem8  (.clk(clk), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .rd(bus8.slave));
  oam_memory u_mem16 (.clk(clk), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .rd(bus16.slave));

  oam_sprite_evaluator #(.SPRITE_HEIGHT(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .scanline(scanline),
    .oam_bus(bus8.master), .sprite_count(count8), .overflow(ov8),
    .busy(busy8), .done(done8), .dbg_state(st8)
  );

  oam_sprite_evaluator #(.SPRITE_HEIGHT(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .scanline(scanline),
    .oam_bus(bus16.master), .sprite_count(count16), .overflow(ov16),
    .busy(busy16), .done(done16), .dbg_state(st16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus8.sprite_we !== 1'b0) begin
      check("h8_write_expected", 64'(exp8_q.size() != 0), 64'd1);
      if (exp8_q.size() != 0)
        check("h8_write", 64'({bus8.sprite_slot, bus8.sprite_entry, bus8.sprite_row}), 64'(exp8_q.pop_front()));
    end
    if (bus16.sprite_we !== 1'b0) begin
      check("h16_write_expected", 64'(exp16_q.size() != 0), 64'd1);
      if (exp16_q.size() != 0)
        check("h16_write", 64'({bus16.sprite_slot, bus16.sprite_entry, bus16.sprite_row}), 64'(exp16_q.pop_front()));
    end
  end

  function automatic logic [31:0] mk(input logic [7:0] x, attr, tile, y);
    return {x, attr, tile, y};
  endfunction

  function automatic logic [W-1:0] wr(input int slot, input logic [31:0] e, input int row);
    return {3'(slot), e, 4'(row)};
  endfunction

  // Reference model of one scan at height h.
  task automatic model_scan(input logic [7:0] sl, input int h, output int cnt, output bit ov);
    int y, diff, row;
    cnt = 0;
    ov  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      y    = int'(shadow[i][7:0]);
      diff = int'(sl) - y;
      if (diff >= 0 && diff < h) begin
        row = shadow[i][23] ? (h - 1 - diff) : diff;
        if (cnt < 8) begin
          if (h == 8) exp8_q.push_back(wr(cnt, shadow[i], row));
          else        exp16_q.push_back(wr(cnt, shadow[i], row));
          cnt++;
        end else begin
          ov = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int idx, input logic [31:0] val);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = {6'(idx), 1'b0}; cpu_wdata = val[15:0];
    @(negedge clk);
    cpu_addr = {6'(idx), 1'b1}; cpu_wdata = val[31:16];
    shadow[idx] = val;
  endtask

  task automatic fill_background();
    for (int i = 0; i < 64; i++) write_entry(i, mk(8'(i * 3), 8'h00, 8'(i), 8'd200));
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic fill_random(input logic [7:0] sl);
    logic [7:0] y;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) y = 8'($urandom_range(0, 255));
      else                           y = sl - 8'($urandom_range(0, 18));
      write_entry(i, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), y));
    end
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] sl, input int c8, input bit o8,
                          input int c16, input bit o16, input int repulse_at);
    int n;
    bit got;
    @(negedge clk);
    scanline = sl;
    start = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy_after_start", 64'(busy8), 64'd1);
      end
      if (n == repulse_at) begin
        start = 1'b1;
        scanline = ~sl;
      end else if (n == repulse_at + 1) begin
        start = 1'b0;
      end
      if (done8 === 1'b1) got = 1'b1;
    end
    check("done_latency", 64'(n), 64'd65);
    check("done16_aligned", 64'(done16), 64'd1);
    check("busy_clear_at_done", 64'({busy8, busy16}), 64'd0);
    check("count_h8", 64'(count8), 64'(c8));
    check("overflow_h8", 64'(ov8), 64'(o8));
    check("count_h16", 64'(count16), 64'(c16));
    check("overflow_h16", 64'(ov16), 64'(o16));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'({done8, done16}), 64'd0);
    check("count_hold", 64'({count8, ov8, count16, ov16}), 64'({4'(c8), o8, 4'(c16), o16}));
    check("queues_drained", 64'(exp8_q.size() + exp16_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bus8"}, 64'({bus8.oam_read_addr, bus8.sprite_we, bus8.sprite_slot, bus8.sprite_entry, bus8.sprite_row}), 64'd0);
    check({tag, "_bus16"}, 64'({bus16.oam_read_addr, bus16.sprite_we, bus16.sprite_slot, bus16.sprite_entry, bus16.sprite_row}), 64'd0);
    check({tag, "_status"}, 64'({count8, ov8, busy8, done8, count16, ov16, busy16, done16}), 64'd0);
    check({tag, "_state"}, 64'({st8, st16}), 64'({ST_IDLE, ST_IDLE}));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c8, c16, dones;
    bit o8, o16;
    logic [7:0] sl;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    fill_background();
    @(negedge clk);
    reset_n = 1'b1;

    // Nothing near line 10.
    run_scan(8'd10, 0, 1'b0, 0, 1'b0, -10);

    // Two hits plus a hit on the last entry, coincident with done.
    shadow[5]  = mk(8'd9, 8'h00, 8'h05, 8'd20);
    shadow[40] = mk(8'd7, 8'h80, 8'h28, 8'd17);
    shadow[63] = mk(8'd1, 8'h00, 8'h3f, 8'd22);
    write_entry(5, shadow[5]);
    write_entry(40, shadow[40]);
    write_entry(63, shadow[63]);
    @(negedge clk) cpu_we = 1'b0;
    exp8_q.push_back(wr(0, shadow[5], 2));
    exp8_q.push_back(wr(1, shadow[40], 2));
    exp8_q.push_back(wr(2, shadow[63], 0));
    exp16_q.push_back(wr(0, shadow[5], 2));
    exp16_q.push_back(wr(1, shadow[40], 10));
    exp16_q.push_back(wr(2, shadow[63], 0));
    run_scan(8'd22, 3, 1'b0, 3, 1'b0, -10);

    // Ten hits at y=50: slots 0..7 fill, the rest set overflow.
    fill_background();
    for (int i = 0; i < 10; i++) write_entry(i, mk(8'(i * 5), 8'h00, 8'(i + 16), 8'd50));
    @(negedge clk) cpu_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp8_q.push_back(wr(i, shadow[i], 3));
      exp16_q.push_back(wr(i, shadow[i], 3));
    end
    run_scan(8'd53, 8, 1'b1, 8, 1'b1, -10);

    // Bottom-edge boundaries at line 255.
    fill_background();
    write_entry(0, mk(8'd4, 8'h00, 8'h01, 8'd240));
    write_entry(1, mk(8'd8, 8'h00, 8'h02, 8'd239));
    @(negedge clk) cpu_we = 1'b0;
    exp16_q.push_back(wr(0, shadow[0], 15));
    run_scan(8'd255, 0, 1'b0, 1, 1'b0, -10);

    // y=250 must not wrap onto line 3.
    write_entry(0, mk(8'd4, 8'h80, 8'h01, 8'd250));
    @(negedge clk) cpu_we = 1'b0;
    run_scan(8'd3, 0, 1'b0, 0, 1'b0, -10);

    // Random OAM, with a stray start at cycle 30 that must be ignored.
    for (int k = 0; k < 3; k++) begin
      sl = 8'($urandom_range(20, 235));
      fill_random(sl);
      model_scan(sl, 8, c8, o8);
      model_scan(sl, 16, c16, o16);
      run_scan(sl, c8, o8, c16, o16, (k == 0) ? 30 : -10);
    end

    // Reset mid-scan: outputs drop at once and no done follows.
    fill_background();
    @(negedge clk);
    scanline = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_midscan");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (done8 === 1'b1 || done16 === 1'b1) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'd0);

    // Normal scan after the abort.
    sl = 8'd77;
    fill_random(sl);
    model_scan(sl, 8, c8, o8);
    model_scan(sl, 16, c16, o16);
    run_scan(sl, c8, o8, c16, o16, -10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
